// File: rtl/sha256_msg_padder_if.sv
// Message stream and memory write bus between the padder and its neighbours.
interface sha256_msg_padder_if #(
    parameter int unsigned ADDR_W = 16
);
    localparam int unsigned DATA_W = 32;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;

    logic              mem_clk;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;

    // Padder side: consumes the message stream, drives the memory port
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data
    );

    // Producer / memory side
    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Writes a word stream into message memory, appends SHA-256 padding to a
// whole number of 16-word blocks, then kicks the SHA core and reports done.
module sha256_msg_padder #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    message_addr,
    sha256_msg_padder_if.slave   bus,
    output logic                 hash_start,
    input  logic                 hash_done,
    output logic [7:0]           num_blocks,
    output logic                 done,
    output logic                 error
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NB_W   = 8;
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] THREE = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_WORDS);
    localparam logic [DATA_W-1:0] PAD_MARKER = 32'h8000_0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PAD_MARK,
        S_PAD_ZERO,
        S_LEN_HI,
        S_LEN_LO,
        S_START,
        S_WAIT_HASH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] t_q, t_d;
    logic [ADDR_W-1:0] n_inc;
    logic [ADDR_W-1:0] blk_total;

    logic              err_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              hs_d;
    logic [NB_W-1:0]   nb_d;

    // Memory is clocked alongside the padder
    assign bus.mem_clk = clk;

    // Padded length if the word now being accepted is the last one:
    // smallest multiple of 16 holding N words + marker + 2 length words
    assign n_inc     = n_q + ONE;
    assign blk_total = (n_inc + ADDR_W'(18)) & ~ADDR_W'(15);

    // Control state and message bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        t_d     = t_q;
        err_d   = error;
        we_d    = 1'b0;
        addr_d  = bus.mem_addr;
        wdata_d = bus.mem_write_data;
        hs_d    = 1'b0;
        nb_d    = num_blocks;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = message_addr;
                    n_d     = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (bus.in_valid) begin
                    if ((n_q == MAX_N) && !bus.in_last) begin
                        // Overlong message: drop the word, report, no hash
                        err_d   = 1'b1;
                        nb_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = base_q + n_q;
                        wdata_d = bus.in_data;
                        n_d     = n_inc;
                        if (bus.in_last) begin
                            idx_d   = n_inc;
                            t_d     = blk_total;
                            nb_d    = NB_W'(blk_total >> 4);
                            state_d = S_PAD_MARK;
                        end
                    end
                end
            end

            S_PAD_MARK: begin
                we_d    = 1'b1;
                addr_d  = base_q + idx_q;
                wdata_d = PAD_MARKER;
                idx_d   = idx_q + ONE;
                // No zero fill when the marker lands right before the length
                state_d = ((idx_q + ONE) == (t_q - TWO)) ? S_LEN_HI : S_PAD_ZERO;
            end

            S_PAD_ZERO: begin
                we_d    = 1'b1;
                addr_d  = base_q + idx_q;
                wdata_d = '0;
                idx_d   = idx_q + ONE;
                if (idx_q == (t_q - THREE)) begin
                    state_d = S_LEN_HI;
                end
            end

            S_LEN_HI: begin
                we_d    = 1'b1;
                addr_d  = base_q + idx_q;
                wdata_d = '0;
                idx_d   = idx_q + ONE;
                state_d = S_LEN_LO;
            end

            S_LEN_LO: begin
                we_d    = 1'b1;
                addr_d  = base_q + idx_q;
                wdata_d = DATA_W'({n_q, 5'b0});
                state_d = S_START;
            end

            S_START: begin
                hs_d    = 1'b1;
                state_d = S_WAIT_HASH;
            end

            S_WAIT_HASH: begin
                if (hash_done) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs; the memory port trails the state by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.in_ready       <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            hash_start         <= 1'b0;
            num_blocks         <= '0;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            bus.in_ready       <= (state_d == S_LOAD);
            bus.mem_we         <= we_d;
            bus.mem_addr       <= addr_d;
            bus.mem_write_data <= wdata_d;
            hash_start         <= hs_d;
            num_blocks         <= nb_d;
            done               <= (state_d == S_DONE);
            error              <= err_d;
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: a write-sequence model built from the
// padding rules is checked on every cycle, plus hand-computed image words.
module tb_sha256_msg_padder;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned MEM_SZ = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              pad;
    } wr_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic              sel;
    logic [ADDR_W-1:0] message_addr;
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_last;
    logic              hash_done;
    logic              hs0, done0, err0;
    logic              hs1, done1, err1;
    logic [7:0]        nb0, nb1;

    int checks;
    int failures;

    wr_t         exp_q[$];
    logic [31:0] mem [MEM_SZ];
    int          pad_cnt, hs_cnt, wr0_cnt, wr1_cnt, hs1_cnt;
    int          exp_nb, exp_pad;
    logic        wrote_prev, hs_prev;
    logic [ADDR_W-1:0] last_addr1;

    sha256_msg_padder_if #(.ADDR_W(ADDR_W)) bus0 ();
    sha256_msg_padder_if #(.ADDR_W(ADDR_W)) bus1 ();

    assign bus0.in_valid = in_valid & ~sel;
    assign bus0.in_data  = in_data;
    assign bus0.in_last  = in_last;
    assign bus1.in_valid = in_valid & sel;
    assign bus1.in_data  = in_data;
    assign bus1.in_last  = in_last;

    sha256_msg_padder #(.MAX_WORDS(1024), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .reset(reset), .start(start & ~sel), .message_addr(message_addr),
        .bus(bus0), .hash_start(hs0), .hash_done(hash_done),
        .num_blocks(nb0), .done(done0), .error(err0)
    );

    sha256_msg_padder #(.MAX_WORDS(4), .ADDR_W(ADDR_W)) u_small (
        .clk(clk), .reset(reset), .start(start & sel), .message_addr(message_addr),
        .bus(bus1), .hash_start(hs1), .hash_done(hash_done),
        .num_blocks(nb1), .done(done1), .error(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'h1111_1111 * 32'(i + 1);
    endfunction

    task automatic push_exp(input int addr, input logic [31:0] data, input logic pad);
        wr_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        e.pad  = pad;
        exp_q.push_back(e);
    endtask

    // Expected write sequence straight from the padding rules
    task automatic build_expected(input int base, input int n);
        int t;
        t = ((n + 3 + 15) / 16) * 16;
        exp_q.delete();
        for (int i = 0; i < n; i++) push_exp(base + i, word_of(i), 1'b0);
        push_exp(base + n, 32'h8000_0000, 1'b1);
        for (int a = n + 1; a <= t - 3; a++) push_exp(base + a, 32'h0, 1'b1);
        push_exp(base + t - 2, 32'h0, 1'b1);
        push_exp(base + t - 1, 32'(n * 32), 1'b1);
        exp_nb  = t / 16;
        exp_pad = t - n;
        pad_cnt = 0;
    endtask

    // Per-cycle compare of the main instance against the model
    always @(negedge clk) begin
        wr_t  e;
        logic need_write;
        if (reset) begin
            wrote_prev = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            need_write = wrote_prev && (exp_q.size() != 0) && exp_q[0].pad;
            if (need_write) chk("pad_contiguous", 32'(bus0.mem_we), 32'd1);
            if (bus0.mem_we) begin
                wr0_cnt++;
                mem[bus0.mem_addr[9:0]] = bus0.mem_write_data;
                chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(bus0.mem_addr), 32'(e.addr));
                    chk("write_data", bus0.mem_write_data, e.data);
                    if (e.pad) pad_cnt++;
                end
            end
            wrote_prev = bus0.mem_we;
            if (hs0) begin
                hs_cnt++;
                chk("hash_after_image", 32'(exp_q.size()), 32'd0);
                chk("hash_one_cycle", 32'(hs_prev), 32'd0);
            end
            hs_prev = hs0;
        end
    end

    // Activity counters for the small-limit instance
    always @(negedge clk) begin
        if (!reset) begin
            if (bus1.mem_we) begin
                wr1_cnt++;
                last_addr1 = bus1.mem_addr;
            end
            if (hs1) hs1_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic which, input int base, input int n,
                            input logic gaps, input logic with_last);
        logic rdy;
        sel          = which;
        message_addr = ADDR_W'(base);
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
            rdy = which ? bus1.in_ready : bus0.in_ready;
            chk("in_ready_load", 32'(rdy), 32'd1);
            if (!rdy) begin
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = word_of(i);
            in_last  = with_last && (i == n - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_hash(input int hs_base);
        int c;
        c = 0;
        while (hs_cnt == hs_base && c < 200) begin
            tick();
            c++;
        end
        tick();
        tick();
        chk("hash_pulses", 32'(hs_cnt - hs_base), 32'd1);
        chk("pad_write_cycles", 32'(pad_cnt), 32'(exp_pad));
        hash_done = 1'b1;
        c = 0;
        do begin
            tick();
            c++;
        end while (!done0 && c < 10);
        chk("done_set", 32'(done0), 32'd1);
        chk("num_blocks", 32'(nb0), 32'(exp_nb));
        chk("error_clear", 32'(err0), 32'd0);
        hash_done = 1'b0;
        tick();
        chk("done_drop", 32'(done0), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_base, wr_base, c;
        logic [31:0] gold;
        checks = 0; failures = 0;
        pad_cnt = 0; hs_cnt = 0; wr0_cnt = 0; wr1_cnt = 0; hs1_cnt = 0;
        wrote_prev = 1'b0; hs_prev = 1'b0; last_addr1 = '0;
        exp_nb = 0; exp_pad = 0;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 32'hDEAD_BEEF;
        reset = 1'b1; start = 1'b0; sel = 1'b0; message_addr = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; hash_done = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus0.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus0.mem_addr), 32'd0);
        chk("rst_mem_data", bus0.mem_write_data, 32'd0);
        chk("rst_hash_start", 32'(hs0), 32'd0);
        chk("rst_num_blocks", 32'(nb0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_error", 32'(err0), 32'd0);
        chk("rst_small_ready", 32'(bus1.in_ready), 32'd0);
        reset = 1'b0;
        tick();

        // N=3 at 0x10
        hs_base = hs_cnt;
        build_expected('h10, 3);
        send_msg(1'b0, 'h10, 3, 1'b0, 1'b1);
        finish_hash(hs_base);
        chk("n3_w0", mem['h10], 32'h1111_1111);
        chk("n3_w2", mem['h12], 32'h3333_3333);
        chk("n3_mark", mem['h13], 32'h8000_0000);
        chk("n3_zero_first", mem['h14], 32'h0);
        chk("n3_zero_last", mem['h1D], 32'h0);
        chk("n3_len_hi", mem['h1E], 32'h0);
        chk("n3_len_lo", mem['h1F], 32'h0000_0060);
        chk("n3_blocks", 32'(nb0), 32'd1);

        // N=20 header at 0
        hs_base = hs_cnt;
        build_expected(0, 20);
        send_msg(1'b0, 0, 20, 1'b0, 1'b1);
        finish_hash(hs_base);
        chk("n20_mark", mem[20], 32'h8000_0000);
        chk("n20_zero21", mem[21], 32'h0);
        chk("n20_zero29", mem[29], 32'h0);
        chk("n20_len_hi", mem[30], 32'h0);
        chk("n20_len_lo", mem[31], 32'h0000_0280);
        chk("n20_blocks", 32'(nb0), 32'd2);
        chk("n20_pad_cycles", 32'(pad_cnt), 32'd12);

        // N=13: marker sits right before the length words
        hs_base = hs_cnt;
        build_expected('h40, 13);
        send_msg(1'b0, 'h40, 13, 1'b0, 1'b1);
        finish_hash(hs_base);
        chk("n13_mark", mem['h4D], 32'h8000_0000);
        chk("n13_len_hi", mem['h4E], 32'h0);
        chk("n13_len_lo", mem['h4F], 32'h0000_01A0);
        chk("n13_pad_cycles", 32'(pad_cnt), 32'd3);
        chk("n13_blocks", 32'(nb0), 32'd1);

        // N=14: spills into a second block
        hs_base = hs_cnt;
        build_expected('h80, 14);
        send_msg(1'b0, 'h80, 14, 1'b0, 1'b1);
        finish_hash(hs_base);
        chk("n14_mark", mem['h8E], 32'h8000_0000);
        chk("n14_zero15", mem['h8F], 32'h0);
        chk("n14_zero29", mem['h9D], 32'h0);
        chk("n14_len_lo", mem['h9F], 32'h0000_01C0);
        chk("n14_blocks", 32'(nb0), 32'd2);

        // N=20 with idle gaps between words
        hs_base = hs_cnt;
        build_expected('h200, 20);
        send_msg(1'b0, 'h200, 20, 1'b1, 1'b1);
        finish_hash(hs_base);
        for (int i = 0; i < 32; i++) begin
            if (i < 20)       gold = word_of(i);
            else if (i == 20) gold = 32'h8000_0000;
            else if (i == 31) gold = 32'h0000_0280;
            else              gold = 32'h0;
            chk("gap_image", mem['h200 + i], gold);
        end

        // Reset while zero-filling
        hs_base = hs_cnt;
        build_expected('h300, 3);
        send_msg(1'b0, 'h300, 3, 1'b0, 1'b1);
        c = 0;
        while (pad_cnt < 2 && c < 50) begin
            tick();
            c++;
        end
        chk("reached_zero_fill", 32'(pad_cnt), 32'd2);
        reset = 1'b1;
        tick();
        chk("abort_mem_we", 32'(bus0.mem_we), 32'd0);
        chk("abort_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("abort_hash_start", 32'(hs0), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        wr_base = wr0_cnt;
        repeat (15) tick();
        chk("abort_no_writes", 32'(wr0_cnt - wr_base), 32'd0);
        chk("abort_no_hash", 32'(hs_cnt - hs_base), 32'd0);
        chk("abort_idle_done", 32'(done0), 32'd0);

        // Restart after abort
        hs_base = hs_cnt;
        build_expected('h300, 13);
        send_msg(1'b0, 'h300, 13, 1'b0, 1'b1);
        finish_hash(hs_base);
        chk("restart_w0", mem['h300], 32'h1111_1111);
        chk("restart_mark", mem['h30D], 32'h8000_0000);
        chk("restart_len_hi", mem['h30E], 32'h0);
        chk("restart_len_lo", mem['h30F], 32'h0000_01A0);

        // Overlong message on the 4-word instance
        wr1_cnt = 0;
        hs1_cnt = 0;
        send_msg(1'b1, 'h20, 5, 1'b0, 1'b0);
        chk("ovf_done", 32'(done1), 32'd1);
        chk("ovf_error", 32'(err1), 32'd1);
        chk("ovf_writes", 32'(wr1_cnt), 32'd4);
        chk("ovf_last_addr", 32'(last_addr1), 32'h23);
        chk("ovf_in_ready", 32'(bus1.in_ready), 32'd0);
        tick();
        chk("ovf_done_drop", 32'(done1), 32'd0);
        chk("ovf_no_hash", 32'(hs1_cnt), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_error_cleared", 32'(err1), 32'd0);
        chk("ovf_reload_ready", 32'(bus1.in_ready), 32'd1);
        repeat (3) tick();
        chk("ovf_still_no_hash", 32'(hs1_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of simplified_sha256: accepts a word-granular message stream, writes it into shared message memory at message_addr, then appends SHA-256 padding (0x80000000 marker, zero fill, 64-bit bit-length) so memory holds whole 16-word blocks.
- After the last padding word it pulses hash_start to the SHA core, waits for hash_done, and then reports done with the block count.
- For an 80-byte Bitcoin header (20 words) it produces the 32-word, 2-block image the core consumes.

Parameters:
- MAX_WORDS, 16'd1024, maximum message words accepted; beyond this the message is rejected.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE to begin a message.
- message_addr  in  ADDR_W  base address for the message image; sampled when start is accepted.
- in_valid  in  1  message word valid.
- in_data  in  32  message word, big-endian.
- in_last  in  1  qualifies in_data as final message word.
- in_ready  out  1  high only in LOAD.
- mem_clk  out  1  equals clk.
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered write address.
- mem_write_data  out  32  registered write data.
- hash_start  out  1  one-cycle pulse to the SHA core.
- hash_done  in  1  SHA core done level.
- num_blocks  out  8  number of 16-word blocks written; valid while done=1.
- done  out  1  held high in DONE.
- error  out  1  held high in DONE if the message was rejected.

Behaviour:
- Reset: state=IDLE. in_ready, mem_we, hash_start, done and error are 0. mem_addr, mem_write_data and num_blocks are 0. Reset mid-operation aborts at the next edge; no further writes are issued.
- IDLE:
  - If start=1: latch base=message_addr, clear word count N, clear error, go to LOAD.
  - mem_we=0.
- LOAD:
  - in_ready=1. On each cycle with in_valid=1: the next cycle presents mem_we=1, mem_addr=base+N, mem_write_data=in_data, and N increments. Idle cycles (in_valid=0) give mem_we=0.
  - in_valid&in_last: go to PAD_MARK.
  - Accepting a word when N==MAX_WORDS without in_last: that word is not written; set error=1 and go to DONE with no hash.
- Block total: T = smallest multiple of 16 with T >= N+3. num_blocks = T/16, registered on leaving LOAD.
- PAD_MARK: 1 cycle. Writes 0x80000000 at base+N.
- PAD_ZERO: writes 0 at base+N+1 .. base+T-3, one word per cycle. Skipped entirely when N+1 == T-2 (e.g. N=13).
- LEN_HI: writes 0 at base+T-2. The bit length never exceeds 32 bits.
- LEN_LO: writes N*32 at base+T-1.
- START: mem_we=0, hash_start=1 for exactly one cycle, go to WAIT_HASH.
- WAIT_HASH: hash_start=0. Stay until hash_done=1, then go to DONE.
- DONE:
  - done=1 (and error if set). num_blocks is stable.
  - Return to IDLE when start=0. done clears on that transition edge.
- Writes are contiguous with no gaps from PAD_MARK through LEN_LO: T-N cycles. in_ready=0 in every state except LOAD.
- N=0 cannot occur, because in_last qualifies a word.
- Widths: N and address arithmetic are ADDR_W bits and wrap modulo 2^ADDR_W. Bit length is computed as {N,5'b0} truncated to 32 bits.

Test Plan:
- N=3 words 0x11111111..0x33333333, base 0x0010 -> mem[0x10..0x12] = data; mem[0x13]=0x80000000; mem[0x14..0x1D]=0; mem[0x1E]=0; mem[0x1F]=0x00000060; num_blocks=1; exactly one hash_start pulse.
- N=20 (Bitcoin header), base 0 -> word20=0x80000000; words21..29=0; word30=0; word31=640 (0x280); num_blocks=2; T-N=12 pad-write cycles.
- Boundary N=13 -> no PAD_ZERO cycles; word14=0; word15=416. Boundary N=14 -> word14=0x80000000; words15..29=0; word31=448; num_blocks=2.
- Backpressure/gaps: in_valid toggled 1,0,0,1,... -> mem_we only on cycles after acceptance; addresses stay consecutive; the final image is identical to the gap-free run.
- Reset asserted during PAD_ZERO -> next cycle mem_we=0, state IDLE, no hash_start. A restart with a new message then produces a correct image.
- MAX_WORDS=4, send 5 words without last -> 4 words written; error=1, done=1, no hash_start; after start=0, done=0 and error clears on the next start.
